// File: rtl/alu_pkg.sv
// Shared opcode, flag-code and FSM-state definitions for the multicycle ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd4;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd5;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd6;
  localparam logic [OP_W-1:0] OP_CMP  = 4'd7;
  localparam logic [OP_W-1:0] OP_BRFL = 4'd8;

  localparam logic [2:0] FLAG_NONE      = 3'd0;
  localparam logic [2:0] FLAG_EQUAL     = 3'd1;
  localparam logic [2:0] FLAG_EXCEPTION = 3'd2;
  localparam logic [2:0] FLAG_OVERFLOW  = 3'd3;
  localparam logic [2:0] FLAG_UNDERFLOW = 3'd4;
  localparam logic [2:0] FLAG_ABOVE     = 3'd5;
  localparam logic [2:0] FLAG_BELOW     = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_RUN,
    ST_DIV_RUN
  } state_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between an EX-stage requester and the multicycle ALU.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FLAG_W = 3
);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic [WIDTH-1:0]  data_a;
  logic [WIDTH-1:0]  data_b;
  logic              out_valid;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  result_hi;
  logic [FLAG_W-1:0] flag;
  logic              branch;

  modport master (
    output in_valid, op, data_a, data_b,
    input  in_ready, out_valid, result, result_hi, flag, branch
  );

  modport slave (
    input  in_valid, op, data_a, data_b,
    output in_ready, out_valid, result, result_hi, flag, branch
  );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per clock.
// next_hi/next_lo expose the step in flight so the final step can be captured on done_c.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] next_lo,
  output logic [WIDTH-1:0] next_hi
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             busy;
  logic             div_mode;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // MUL: hi:lo is accumulator:multiplier; DIV: hi:lo is remainder:quotient.
  always_comb begin
    addend  = lo[0] ? {1'b0, opnd} : '0;
    add_sum = {1'b0, hi} + addend;
    shifted = {hi, lo[WIDTH-1]};
    trial   = shifted - {1'b0, opnd};
    next_hi = add_sum[WIDTH:1];
    next_lo = {add_sum[0], lo[WIDTH-1:1]};
    if (div_mode) begin
      if (trial[WIDTH]) begin
        next_hi = shifted[WIDTH-1:0];
        next_lo = {lo[WIDTH-2:0], 1'b0};
      end else begin
        next_hi = trial[WIDTH-1:0];
        next_lo = {lo[WIDTH-2:0], 1'b1};
      end
    end
  end

  assign done_c = busy && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      div_mode <= is_div;
      cnt      <= '0;
      hi       <= '0;
      lo       <= is_div ? a : b;
      opnd     <= is_div ? b : a;
    end else if (busy) begin
      hi  <= next_hi;
      lo  <= next_lo;
      cnt <= cnt + CNT_W'(1);
      if (done_c) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle datapath, persistent flag/branch registers and
// an FSM that hands MUL/DIV to the iterative unit.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FLAG_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  alu_multicycle_if.slave  bus
);

  state_t            state;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]  result_hi_q;
  logic [FLAG_W-1:0] flag_q;
  logic              branch_q;

  logic              accept;
  logic              b_zero;
  logic              md_start;
  logic              md_done_c;
  logic [WIDTH-1:0]  md_lo;
  logic [WIDTH-1:0]  md_hi;

  logic [WIDTH-1:0]  sum;
  logic [WIDTH-1:0]  diff;
  logic              a_s;
  logic              b_s;
  logic [WIDTH-1:0]  sc_result;
  logic [WIDTH-1:0]  sc_hi;
  logic [FLAG_W-1:0] sc_flag;
  logic              sc_flag_we;
  logic              sc_branch;
  logic              sc_branch_we;

  assign accept   = bus.in_valid && in_ready_q;
  assign b_zero   = (bus.data_b == '0);
  assign md_start = accept && ((bus.op == OP_MUL) || ((bus.op == OP_DIV) && !b_zero));

  assign sum  = bus.data_a + bus.data_b;
  assign diff = bus.data_a - bus.data_b;
  assign a_s  = bus.data_a[WIDTH-1];
  assign b_s  = bus.data_b[WIDTH-1];

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clock   (clock),
    .reset   (reset),
    .start   (md_start),
    .is_div  (bus.op == OP_DIV),
    .a       (bus.data_a),
    .b       (bus.data_b),
    .done_c  (md_done_c),
    .next_lo (md_lo),
    .next_hi (md_hi)
  );

  // Single-cycle results, including the divide-by-zero short cut.
  always_comb begin
    sc_result    = '0;
    sc_hi        = '0;
    sc_flag      = FLAG_W'(FLAG_NONE);
    sc_flag_we   = 1'b1;
    sc_branch    = 1'b0;
    sc_branch_we = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_result = sum;
        if (!a_s && !b_s && sum[WIDTH-1]) begin
          sc_flag = FLAG_W'(FLAG_OVERFLOW);
        end else if (a_s && b_s && !sum[WIDTH-1]) begin
          sc_flag = FLAG_W'(FLAG_UNDERFLOW);
        end
      end
      OP_SUB: begin
        sc_result = diff;
        if (!a_s && b_s && diff[WIDTH-1]) begin
          sc_flag = FLAG_W'(FLAG_OVERFLOW);
        end else if (a_s && !b_s && !diff[WIDTH-1]) begin
          sc_flag = FLAG_W'(FLAG_UNDERFLOW);
        end
      end
      OP_AND: sc_result = bus.data_a & bus.data_b;
      OP_OR:  sc_result = bus.data_a | bus.data_b;
      OP_NOT: sc_result = ~bus.data_b;
      OP_MUL: sc_flag_we = 1'b0;
      OP_DIV: begin
        sc_result = '1;
        sc_hi     = bus.data_a;
        sc_flag   = FLAG_W'(FLAG_EXCEPTION);
      end
      OP_CMP: begin
        if (bus.data_a == bus.data_b) begin
          sc_flag = FLAG_W'(FLAG_EQUAL);
        end else if (bus.data_a > bus.data_b) begin
          sc_flag = FLAG_W'(FLAG_ABOVE);
        end else begin
          sc_flag = FLAG_W'(FLAG_BELOW);
        end
      end
      OP_BRFL: begin
        sc_result    = bus.data_a;
        sc_flag_we   = 1'b0;
        sc_branch    = (flag_q == bus.data_b[FLAG_W-1:0]);
        sc_branch_we = 1'b1;
      end
      default: sc_flag = FLAG_W'(FLAG_EXCEPTION);
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flag_q      <= FLAG_W'(FLAG_NONE);
      branch_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (md_start) begin
            state      <= (bus.op == OP_MUL) ? ST_MUL_RUN : ST_DIV_RUN;
            in_ready_q <= 1'b0;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= sc_result;
            result_hi_q <= sc_hi;
            if (sc_flag_we) begin
              flag_q <= sc_flag;
            end
            if (sc_branch_we) begin
              branch_q <= sc_branch;
            end
          end
        end
        ST_MUL_RUN, ST_DIV_RUN: begin
          if (md_done_c) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b1;
            result_q    <= md_lo;
            result_hi_q <= md_hi;
            flag_q      <= ((state == ST_MUL_RUN) && (md_hi != '0)) ?
                           FLAG_W'(FLAG_OVERFLOW) : FLAG_W'(FLAG_NONE);
          end
        end
        default: begin
          state      <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flag      = flag_q;
  assign bus.branch    = branch_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: scoreboard of modelled results vs. observed completions.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  typedef struct {
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [2:0]   flag;
    logic         branch;
    int           cyc;
  } rec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_multicycle_if #(.WIDTH(W), .FLAG_W(3)) bus ();

  alu_multicycle #(.WIDTH(W), .FLAG_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];
  logic [2:0] m_flag = 3'd0;
  logic       m_branch = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    rec_t r;
    if (bus.out_valid === 1'b1) begin
      r.result = bus.result;
      r.hi     = bus.result_hi;
      r.flag   = bus.flag;
      r.branch = bus.branch;
      r.cyc    = cyc;
      obs_q.push_back(r);
    end
  end

  // Reference model: wide arithmetic, updates the modelled flag/branch state.
  function automatic rec_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    rec_t r;
    longint s;
    logic [63:0] p;
    r.result = '0;
    r.hi     = '0;
    r.cyc    = 0;
    case (o)
      OP_ADD: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r.result = a + b;
        m_flag = (s > SMAX) ? FLAG_OVERFLOW : (s < SMIN) ? FLAG_UNDERFLOW : FLAG_NONE;
      end
      OP_SUB: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r.result = a - b;
        m_flag = (s > SMAX) ? FLAG_OVERFLOW : (s < SMIN) ? FLAG_UNDERFLOW : FLAG_NONE;
      end
      OP_AND: begin r.result = a & b; m_flag = FLAG_NONE; end
      OP_OR:  begin r.result = a | b; m_flag = FLAG_NONE; end
      OP_NOT: begin r.result = ~b;    m_flag = FLAG_NONE; end
      OP_MUL: begin
        p = 64'(a) * 64'(b);
        r.result = p[31:0];
        r.hi     = p[63:32];
        m_flag   = (p[63:32] != '0) ? FLAG_OVERFLOW : FLAG_NONE;
      end
      OP_DIV: begin
        if (b == '0) begin
          r.result = 32'hFFFF_FFFF;
          r.hi     = a;
          m_flag   = FLAG_EXCEPTION;
        end else begin
          r.result = a / b;
          r.hi     = a % b;
          m_flag   = FLAG_NONE;
        end
      end
      OP_CMP: m_flag = (a == b) ? FLAG_EQUAL : (a > b) ? FLAG_ABOVE : FLAG_BELOW;
      OP_BRFL: begin
        r.result = a;
        m_branch = (m_flag == b[2:0]);
      end
      default: m_flag = FLAG_EXCEPTION;
    endcase
    r.flag   = m_flag;
    r.branch = m_branch;
    return r;
  endfunction

  // Present one request at a falling edge; the next rising edge accepts it.
  task automatic drive_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    rec_t e;
    int n;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.data_a   = a;
    bus.data_b   = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    e = model(o, a, b);
    e.cyc = cyc + (((o == OP_MUL) || ((o == OP_DIV) && (b != '0))) ? int'(W) + 1 : 1);
    exp_q.push_back(e);
  endtask

  task automatic run_one(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    drive_op(o, a, b);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  // Bounded wait for the next completion; pairs it with the oldest expectation.
  task automatic get_pair(output rec_t o, output rec_t e);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < 80) begin
      @(posedge clock);
      n++;
    end
    o.result = 'x; o.hi = 'x; o.flag = 'x; o.branch = 1'bx; o.cyc = -1;
    e = o;
    if (obs_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: no out_valid within %0d cycles, required one", n);
    end else begin
      o = obs_q.pop_front();
    end
    if (exp_q.size() != 0) e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks += 6;
    if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    if (bus.result !== '0)      begin errors++; $display("FAIL reset_result: got %h required 0", bus.result); end
    if (bus.result_hi !== '0)   begin errors++; $display("FAIL reset_result_hi: got %h required 0", bus.result_hi); end
    if (bus.flag !== 3'd0)      begin errors++; $display("FAIL reset_flag: got %0d required 0", bus.flag); end
    if (bus.branch !== 1'b0)    begin errors++; $display("FAIL reset_branch: got %b required 0", bus.branch); end
  endtask

  // Runs a table of ops one at a time and compares each completion.
  task automatic run_table(input string nm, input logic [3:0] ops[$], input logic [W-1:0] as[$], input logic [W-1:0] bs[$]);
    rec_t o, e;
    foreach (ops[i]) begin
      run_one(ops[i], as[i], bs[i]);
      get_pair(o, e);
      checks++;
      if (o.result !== e.result || o.hi !== e.hi || o.flag !== e.flag || o.branch !== e.branch || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL %s[%0d]: got result=%h hi=%h flag=%0d branch=%b cyc=%0d, required result=%h hi=%h flag=%0d branch=%b cyc=%0d",
                 nm, i, o.result, o.hi, o.flag, o.branch, o.cyc, e.result, e.hi, e.flag, e.branch, e.cyc);
      end
    end
  endtask

  task automatic test_add_sub();
    run_table("add_sub",
      '{OP_ADD, OP_SUB, OP_ADD, OP_ADD, OP_SUB, OP_SUB},
      '{32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd3},
      '{32'd1, 32'd1, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd10});
  endtask

  task automatic test_logic();
    run_table("logic",
      '{OP_AND, OP_OR, OP_NOT},
      '{32'hF0F0_1234, 32'h0F00_0001, 32'h1111_1111},
      '{32'hFF00_FF00, 32'h00F0_8000, 32'h0000_FFFF});
  endtask

  task automatic test_cmp_brfl();
    run_table("cmp_brfl",
      '{OP_CMP, OP_BRFL, OP_BRFL, OP_CMP, OP_BRFL, OP_CMP, OP_BRFL},
      '{32'd5, 32'h1234, 32'h55, 32'd3, 32'd77, 32'd9, 32'd88},
      '{32'd5, 32'd1, 32'd5, 32'd9, 32'd6, 32'd3, 32'h0000_0005});
  endtask

  task automatic test_illegal();
    run_table("illegal",
      '{4'd9, OP_ADD, 4'd15, OP_BRFL},
      '{32'd1, 32'd1, 32'hABCD, 32'd42},
      '{32'd2, 32'd1, 32'h1, 32'd2});
  endtask

  task automatic test_mul();
    rec_t o, e;
    int busy_cycles;
    drive_op(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    busy_cycles = 0;
    // Hold a competing request during the run; it must be ignored.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1 || k == 11) bus.in_valid = 1'b0;
      else if (k < 11) begin
        bus.in_valid = 1'b1; bus.op = OP_ADD; bus.data_a = 32'd1; bus.data_b = 32'd1;
      end
      if (bus.out_valid === 1'b1) break;
      if (bus.in_ready === 1'b0) busy_cycles++;
    end
    bus.in_valid = 1'b0;
    get_pair(o, e);
    checks += 3;
    if (o.result !== e.result || o.hi !== e.hi || o.flag !== e.flag || o.cyc != e.cyc) begin
      errors++;
      $display("FAIL mul_big: got result=%h hi=%h flag=%0d cyc=%0d, required result=%h hi=%h flag=%0d cyc=%0d",
               o.result, o.hi, o.flag, o.cyc, e.result, e.hi, e.flag, e.cyc);
    end
    if (busy_cycles != 32) begin
      errors++;
      $display("FAIL mul_in_ready_low: got %0d cycles required 32", busy_cycles);
    end
    repeat (3) @(negedge clock);
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL mul_ignored_request: got %0d extra completions required 0", obs_q.size());
      obs_q.delete();
    end
    run_table("mul",
      '{OP_MUL, OP_MUL, OP_MUL},
      '{32'd3, 32'hFFFF_FFFF, 32'h1234_5678},
      '{32'd5, 32'hFFFF_FFFF, 32'h0000_0000});
  endtask

  task automatic test_div();
    run_table("div",
      '{OP_DIV, OP_DIV, OP_DIV, OP_DIV, OP_DIV},
      '{32'd100, 32'd5, 32'hFFFF_FFFF, 32'd3, 32'h8000_0001},
      '{32'd7, 32'd0, 32'd1, 32'd10, 32'hFFFF_FFFF});
  endtask

  task automatic test_reset_mid_mul();
    run_table("pre_abort", '{OP_ADD}, '{32'h7FFF_FFFF}, '{32'd1});
    @(negedge clock);
    bus.in_valid = 1'b1; bus.op = OP_MUL; bus.data_a = 32'h0001_0000; bus.data_b = 32'h0001_0000;
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_flag = FLAG_NONE;
    m_branch = 1'b0;
    checks += 6;
    if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL abort_in_ready: got %b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b required 0", bus.out_valid); end
    if (bus.result !== '0)      begin errors++; $display("FAIL abort_result: got %h required 0", bus.result); end
    if (bus.result_hi !== '0)   begin errors++; $display("FAIL abort_result_hi: got %h required 0", bus.result_hi); end
    if (bus.flag !== 3'd0)      begin errors++; $display("FAIL abort_flag: got %0d required 0", bus.flag); end
    if (bus.branch !== 1'b0)    begin errors++; $display("FAIL abort_branch: got %b required 0", bus.branch); end
    repeat (W + 5) @(negedge clock);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL abort_no_completion: got %0d completions required 0", obs_q.size());
      obs_q.delete();
    end
    run_table("post_abort", '{OP_ADD}, '{32'd2}, '{32'd3});
  endtask

  task automatic test_back_to_back();
    rec_t o[3], e[3];
    drive_op(OP_ADD, 32'd10, 32'd20);
    drive_op(OP_AND, 32'hF0F0_F0F0, 32'h3C3C_3C3C);
    drive_op(OP_OR,  32'h0000_00F0, 32'h0000_0F00);
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      get_pair(o[i], e[i]);
      checks++;
      if (o[i].result !== e[i].result || o[i].hi !== e[i].hi || o[i].flag !== e[i].flag || o[i].cyc != e[i].cyc) begin
        errors++;
        $display("FAIL b2b[%0d]: got result=%h hi=%h flag=%0d cyc=%0d, required result=%h hi=%h flag=%0d cyc=%0d",
                 i, o[i].result, o[i].hi, o[i].flag, o[i].cyc, e[i].result, e[i].hi, e[i].flag, e[i].cyc);
      end
    end
    checks++;
    if (o[2].cyc - o[0].cyc != 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles from first to third required 2", o[2].cyc - o[0].cyc);
    end
  endtask

  task automatic test_random();
    logic [3:0]   ops[$];
    logic [W-1:0] as[$];
    logic [W-1:0] bs[$];
    for (int i = 0; i < 24; i++) begin
      ops.push_back(4'($urandom_range(0, 8)));
      as.push_back($urandom());
      bs.push_back((i % 3 == 0) ? W'($urandom_range(0, 20)) : $urandom());
    end
    run_table("random", ops, as, bs);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.data_a   = '0;
    bus.data_b   = '0;
    test_reset();
    test_add_sub();
    test_logic();
    test_cmp_brfl();
    test_illegal();
    test_mul();
    test_div();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
